// File: rtl/sr_monitor.sv
// sr_monitor: shadows an SR flip-flop with a reference model and flags output disagreements.
// Optional build macro SR_COVER_EN adds the cov_seen/cov_done coverage outputs.
module sr_monitor #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    output logic             mismatch,
    output logic             comp_err,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [CNT_W-1:0] first_err_cyc,
    output logic             halted
`ifdef SR_COVER_EN
    ,
    output logic [3:0]       cov_seen,
    output logic             cov_done
`endif
);

    typedef enum logic [1:0] {WARM, TRACK, UNKNOWN, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             model_q, model_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             mm_q, mm_d, ce_q, ce_d, il_q, il_d, err_q, err_d;
    logic [CNT_W-1:0] mmCnt_q, mmCnt_d, ilCnt_q, ilCnt_d, first_q, first_d;

    logic chkActive, mmHit, ceHit, ilHit, errStop;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // q is only compared while the model is known; the complement check needs no model.
    assign chkActive = (state_q == TRACK) || (state_q == UNKNOWN);
    assign mmHit     = (state_q == TRACK) && (q != model_q);
    assign ceHit     = chkActive && (qbar == q);
    assign ilHit     = chkActive && s && r;
    assign errStop   = STOP_ON_ERR && (mmHit || ceHit) && !clr;

    always_comb begin
        state_d = state_q;
        model_d = model_q;
        cyc_d   = cyc_q;
        mm_d    = 1'b0;
        ce_d    = 1'b0;
        il_d    = 1'b0;
        err_d   = err_q;
        mmCnt_d = mmCnt_q;
        ilCnt_d = ilCnt_q;
        first_d = first_q;

        if (state_q != HALT) begin
            case ({s, r})
                2'b01:   model_d = 1'b0;
                2'b10:   model_d = 1'b1;
                default: model_d = model_q;
            endcase
        end

        case (state_q)
            WARM: state_d = (s && r) ? UNKNOWN : TRACK;
            TRACK, UNKNOWN: begin
                if (errStop)     state_d = HALT;
                else if (s && r) state_d = UNKNOWN;
                else if (s != r) state_d = TRACK;
            end
            default: state_d = HALT;
        endcase

        if (chkActive) begin
            cyc_d = satInc(cyc_q);
            mm_d  = mmHit;
            ce_d  = ceHit;
            il_d  = ilHit;
            if (mmHit) mmCnt_d = satInc(mmCnt_q);
            if (ilHit) ilCnt_d = satInc(ilCnt_q);
            if (mmHit || ceHit) begin
                err_d = 1'b1;
                if (!err_q) first_d = cyc_q;
            end
        end

        // Clear overrides any same-edge error; after HALT the model cannot be trusted.
        if (clr) begin
            cyc_d   = '0;
            mm_d    = 1'b0;
            ce_d    = 1'b0;
            il_d    = 1'b0;
            err_d   = 1'b0;
            mmCnt_d = '0;
            ilCnt_d = '0;
            first_d = '0;
            if (state_q == HALT) state_d = UNKNOWN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WARM;
            model_q <= 1'b0;
            cyc_q   <= '0;
            mm_q    <= 1'b0;
            ce_q    <= 1'b0;
            il_q    <= 1'b0;
            err_q   <= 1'b0;
            mmCnt_q <= '0;
            ilCnt_q <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            model_q <= model_d;
            cyc_q   <= cyc_d;
            mm_q    <= mm_d;
            ce_q    <= ce_d;
            il_q    <= il_d;
            err_q   <= err_d;
            mmCnt_q <= mmCnt_d;
            ilCnt_q <= ilCnt_d;
            first_q <= first_d;
        end
    end

    assign mismatch      = mm_q;
    assign comp_err      = ce_q;
    assign illegal       = il_q;
    assign err           = err_q;
    assign mismatch_cnt  = mmCnt_q;
    assign illegal_cnt   = ilCnt_q;
    assign first_err_cyc = first_q;
    assign halted        = (state_q == HALT);

`ifdef SR_COVER_EN
    logic [3:0] cov_q, cov_d;
    logic       qPrev_q;

    always_comb begin
        cov_d = cov_q;
        if (state_q == TRACK) begin
            if ({s, r} == 2'b00) cov_d[0] = 1'b1;
            if ({s, r} == 2'b01) cov_d[1] = 1'b1;
            if ({s, r} == 2'b10) cov_d[2] = 1'b1;
            if (!qPrev_q && q)   cov_d[3] = 1'b1;
        end
        if (clr) cov_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cov_q   <= '0;
            qPrev_q <= 1'b0;
        end else begin
            cov_q   <= cov_d;
            qPrev_q <= q;
        end
    end

    assign cov_seen = cov_q;
    assign cov_done = &cov_q;
`endif

endmodule

// File: tb/tb_sr_monitor.sv
// tb_sr_monitor: directed vectors against three sr_monitor builds (default, stop-on-error, 2-bit counters).
// Expected responses go into a scoreboard queue; a monitor process pops one per clock and compares.
module tb_sr_monitor;

    typedef struct packed {
        logic       mm;
        logic       ce;
        logic       il;
        logic       err;
        logic       halted;
        logic [7:0] mmCnt;
        logic [7:0] ilCnt;
        logic [7:0] first;
    } obs_t;

    logic clk = 1'b0;
    logic rst, clr, s, r, q, qbar;

    logic       mm0, ce0, il0, err0, halt0;
    logic [7:0] mmc0, ilc0, fec0;
    logic       mm1, ce1, il1, err1, halt1;
    logic [7:0] mmc1, ilc1, fec1;
    logic       mm2, ce2, il2, err2, halt2;
    logic [1:0] mmc2, ilc2, fec2;
`ifdef SR_COVER_EN
    logic [3:0] cov0, cov1, cov2;
    logic       cd0, cd1, cd2;
`endif

    obs_t  expQ[$];
    int    selQ[$];
    string nameQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    always #5 clk = ~clk;

    sr_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
        .mismatch(mm0), .comp_err(ce0), .illegal(il0), .err(err0),
        .mismatch_cnt(mmc0), .illegal_cnt(ilc0), .first_err_cyc(fec0), .halted(halt0)
`ifdef SR_COVER_EN
        , .cov_seen(cov0), .cov_done(cd0)
`endif
    );

    sr_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
        .mismatch(mm1), .comp_err(ce1), .illegal(il1), .err(err1),
        .mismatch_cnt(mmc1), .illegal_cnt(ilc1), .first_err_cyc(fec1), .halted(halt1)
`ifdef SR_COVER_EN
        , .cov_seen(cov1), .cov_done(cd1)
`endif
    );

    sr_monitor #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
        .mismatch(mm2), .comp_err(ce2), .illegal(il2), .err(err2),
        .mismatch_cnt(mmc2), .illegal_cnt(ilc2), .first_err_cyc(fec2), .halted(halt2)
`ifdef SR_COVER_EN
        , .cov_seen(cov2), .cov_done(cd2)
`endif
    );

    function automatic obs_t mk(input logic mm, input logic ce, input logic il, input logic er,
                                input int mc, input int ic, input int fe, input logic h);
        obs_t o;
        o.mm     = mm;
        o.ce     = ce;
        o.il     = il;
        o.err    = er;
        o.halted = h;
        o.mmCnt  = 8'(mc);
        o.ilCnt  = 8'(ic);
        o.first  = 8'(fe);
        return o;
    endfunction

    function automatic obs_t actualOf(input int sel);
        obs_t o;
        case (sel)
            1:       o = '{mm1, ce1, il1, err1, halt1, mmc1, ilc1, fec1};
            2:       o = '{mm2, ce2, il2, err2, halt2, {6'b0, mmc2}, {6'b0, ilc2}, {6'b0, fec2}};
            default: o = '{mm0, ce0, il0, err0, halt0, mmc0, ilc0, fec0};
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t got, input obs_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got mm=%0b ce=%0b il=%0b err=%0b halt=%0b mcnt=%0d icnt=%0d first=%0d, expected mm=%0b ce=%0b il=%0b err=%0b halt=%0b mcnt=%0d icnt=%0d first=%0d",
                     name, got.mm, got.ce, got.il, got.err, got.halted, got.mmCnt, got.ilCnt, got.first,
                     want.mm, want.ce, want.il, want.err, want.halted, want.mmCnt, want.ilCnt, want.first);
        end
    endtask

    // Drives one edge's worth of inputs and queues the response expected after that edge.
    task automatic applyStimulus(input int sel, input string name, input logic iS, input logic iR,
                                 input logic iQ, input logic iQb, input logic iClr, input obs_t e);
        @(negedge clk);
        rst  = 1'b1;
        clr  = iClr;
        s    = iS;
        r    = iR;
        q    = iQ;
        qbar = iQb;
        expQ.push_back(e);
        selQ.push_back(sel);
        nameQ.push_back(name);
    endtask

    task automatic doReset(input int sel);
        @(negedge clk);
        rst  = 1'b0;
        clr  = 1'b0;
        s    = 1'b0;
        r    = 1'b0;
        q    = 1'b0;
        qbar = 1'b1;
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        selQ.push_back(sel);
        nameQ.push_back("reset");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                obs_t  e;
                int    sel;
                string nm;
                e   = expQ.pop_front();
                sel = selQ.pop_front();
                nm  = nameQ.pop_front();
                checkOutput(nm, actualOf(sel), e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        obs_t z;
        z    = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst  = 1'b0;
        clr  = 1'b0;
        s    = 1'b0;
        r    = 1'b0;
        q    = 1'b0;
        qbar = 1'b1;

        $display("[TB] reset then hold");
        doReset(0);
        for (int i = 0; i < 10; i++) applyStimulus(0, "hold", 0, 0, 0, 1, 0, z);

        $display("[TB] set/reset sequence");
        doReset(0);
        applyStimulus(0, "sr_warm",   0, 0, 0, 1, 0, z);
        applyStimulus(0, "sr_set",    1, 0, 0, 1, 0, z);
        applyStimulus(0, "sr_hold1",  0, 0, 1, 0, 0, z);
        applyStimulus(0, "sr_reset",  0, 1, 1, 0, 0, z);
        applyStimulus(0, "sr_hold0",  0, 0, 0, 1, 0, z);
        applyStimulus(0, "sr_hold0b", 0, 0, 0, 1, 0, z);

        $display("[TB] mismatch injection");
        doReset(0);
        applyStimulus(0, "mm_warm", 0, 0, 0, 1, 0, z);
        for (int i = 0; i < 5; i++) applyStimulus(0, "mm_pre", 0, 0, 0, 1, 0, z);
        applyStimulus(0, "mm_first",  0, 0, 1, 0, 0, mk(1, 0, 0, 1, 1, 0, 5, 0));
        applyStimulus(0, "mm_ok",     0, 0, 0, 1, 0, mk(0, 0, 0, 1, 1, 0, 5, 0));
        applyStimulus(0, "mm_second", 0, 0, 1, 0, 0, mk(1, 0, 0, 1, 2, 0, 5, 0));
        applyStimulus(0, "mm_after",  0, 0, 0, 1, 0, mk(0, 0, 0, 1, 2, 0, 5, 0));

        $display("[TB] illegal request");
        doReset(0);
        applyStimulus(0, "ill_warm",   0, 0, 0, 1, 0, z);
        applyStimulus(0, "ill_pre",    0, 0, 0, 1, 0, z);
        applyStimulus(0, "ill_1",      1, 1, 0, 1, 0, mk(0, 0, 1, 0, 0, 1, 0, 0));
        applyStimulus(0, "ill_2",      1, 1, 1, 0, 0, mk(0, 0, 1, 0, 0, 2, 0, 0));
        applyStimulus(0, "ill_exit",   1, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 2, 0, 0));
        applyStimulus(0, "ill_track",  0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 2, 0, 0));
        applyStimulus(0, "ill_resume", 0, 0, 0, 1, 0, mk(1, 0, 0, 1, 1, 2, 5, 0));

        $display("[TB] complement fault and clear");
        doReset(0);
        applyStimulus(0, "comp_warm",   0, 0, 0, 1, 0, z);
        applyStimulus(0, "comp_pre",    0, 0, 0, 1, 0, z);
        applyStimulus(0, "comp_both",   0, 0, 1, 1, 0, mk(1, 1, 0, 1, 1, 0, 1, 0));
        applyStimulus(0, "comp_after",  0, 0, 0, 1, 0, mk(0, 0, 0, 1, 1, 0, 1, 0));
        applyStimulus(0, "clr_wins",    0, 0, 1, 1, 1, z);
        applyStimulus(0, "post_clr",    0, 0, 0, 1, 0, z);
        applyStimulus(0, "post_clr_mm", 0, 0, 1, 0, 0, mk(1, 0, 0, 1, 1, 0, 1, 0));

        $display("[TB] stop on error");
        doReset(1);
        applyStimulus(1, "halt_warm",    0, 0, 0, 1, 0, z);
        applyStimulus(1, "halt_pre",     0, 0, 0, 1, 0, z);
        applyStimulus(1, "halt_enter",   0, 0, 1, 1, 0, mk(1, 1, 0, 1, 1, 0, 1, 1));
        applyStimulus(1, "halt_frozen",  1, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 0, 1, 1));
        applyStimulus(1, "halt_frozen2", 0, 0, 1, 1, 0, mk(0, 0, 0, 1, 1, 0, 1, 1));
        applyStimulus(1, "halt_clr",     0, 0, 0, 1, 1, z);
        applyStimulus(1, "unk_after",    1, 0, 0, 1, 0, z);
        applyStimulus(1, "track_after",  0, 0, 1, 0, 0, z);
        applyStimulus(1, "stop_again",   0, 0, 0, 1, 0, mk(1, 0, 0, 1, 1, 0, 2, 1));

        $display("[TB] counter saturation");
        doReset(2);
        applyStimulus(2, "sat_warm", 0, 0, 0, 1, 0, z);
        for (int i = 1; i <= 6; i++)
            applyStimulus(2, "sat_mm", 0, 0, 1, 0, 0, mk(1, 0, 0, 1, (i > 3) ? 3 : i, 0, 0, 0));

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
